mole_scheduler: RTL and testbench
=================================

// Module: mole_scheduler
// PURPOSE
//   Game-control stage downstream of the 4-bit LFSR. Samples the free-running
//   random value to pick which hole's mole to raise, times the up/gap windows,
//   detects player hits from button presses, and keeps score and miss counts.
//   Drives the mole LEDs directly; score/misses feed the display stage.
// PARAMETERS
//   NUM_HOLES   4         holes/LEDs; power of 2, 2..16; index = rnd[log2(NUM_HOLES)-1:0]
//   UP_CYCLES   25000000  clocks a mole stays raised (>=2)
//   GAP_CYCLES  12500000  clocks between moles (>=1)
//   MAX_MISSES  3         misses that end the game (1..3)
//   SCORE_W     8         score width
// PORTS
//   clk        in   1          system clock
//   rst        in   1          synchronous, active-high reset
//   start      in   1          start/restart request, sampled in IDLE and OVER only
//   rnd        in   4          LFSR random value (q), valid every cycle
//   btn        in   NUM_HOLES  debounced hit buttons, level, bit i = hole i
//   mole       out  NUM_HOLES  one-hot raised mole, all-zero when none
//   score      out  SCORE_W    hits this game, saturating
//   misses     out  2          missed moles this game
//   hit_pulse  out  1          one-cycle strobe per registered hit
//   game_over  out  1          high while in OVER
// BEHAVIOUR
//   Reset: state=IDLE; mole=0, score=0, misses=0, hit_pulse=0, game_over=0,
//     timer=0, prev_idx=0, btn_q=0. Reset mid-game aborts at once, no residue.
//   All outputs registered. btn_q <= btn every cycle in every state.
//     edge[i] = btn[i] & ~btn_q[i].
//   FSM:
//   - IDLE: mole=0. start=1 -> GAP; score, misses cleared; timer=0.
//   - GAP: mole=0. Lasts exactly GAP_CYCLES cycles. In the last cycle:
//       idx = rnd low bits; if idx==prev_idx then idx=(idx+1) mod NUM_HOLES
//       (no back-to-back repeat; NUM_HOLES-1 wraps to 0).
//       Latch prev_idx=idx. Next cycle -> UP with mole=onehot(idx).
//       Fixed: the first mole of a game also compares against prev_idx
//       (0 after reset).
//   - UP: mole held exactly UP_CYCLES cycles unless hit.
//     * edge[idx] in cycle t -> at t+1: score+1 (saturates at all-ones),
//       hit_pulse=1 for that cycle only, mole=0, state GAP, timer=0.
//     * Edges on other bits are ignored, with no penalty.
//     * A button already high on UP entry does not count until released and
//       re-pressed.
//     * Timer expiry with no hit -> misses+1. If the new count == MAX_MISSES,
//       go to OVER; otherwise go to GAP.
//     * Hit and expiry in the same cycle: the hit wins and misses are
//       unchanged.
//   - OVER: mole=0, game_over=1; score/misses held.
//       start=1 -> GAP with counters cleared and game_over=0 the next cycle.
//   start in GAP/UP is ignored.
//   Every transition takes one cycle; no combinational path from inputs to
//   outputs.
// TESTING (UP_CYCLES=8, GAP_CYCLES=4, MAX_MISSES=3, NUM_HOLES=4)
//   1 Reset: assert rst 2 cycles mid-UP -> next cycle all outputs 0, IDLE;
//     start ignored while rst=1.
//   2 Pulse start, rnd=4'b0110 in last GAP cycle -> mole=4'b0100 for exactly
//     8 cycles; no press -> mole=0, misses=1, 4-cycle gap follows.
//   3 Mole on hole 2, btn[2] rises in 3rd UP cycle -> next cycle hit_pulse=1
//     (1 cycle), score=1, mole=0. btn[1] presses and a btn[2] held from before
//     UP -> no score.
//   4 Repeat avoidance: prev_idx=2, rnd low bits=2 -> mole=4'b1000.
//     prev_idx=3, rnd=3 -> mole=4'b0001.
//   5 Three unhit moles -> after 3rd expiry game_over=1, mole=0, misses=3.
//     start -> game_over=0, score=0, misses=0, GAP begins.
//   6 btn[idx] rising in final UP cycle -> score increments, misses unchanged.
//     With SCORE_W=2, 5 hits -> score stays 3.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game control.
//   Picks a hole from the free-running LFSR value, raises that hole's mole for
//   UP_CYCLES clocks, separates moles by GAP_CYCLES idle clocks, scores hits
//   from rising button edges and counts expired moles until MAX_MISSES ends
//   the game.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      start/restart request (honoured in idle and game-over only)
//   rnd        LFSR value, low log2(NUM_HOLES) bits select the hole
//   btn        debounced hit buttons, bit i = hole i
//   mole       one-hot raised mole, zero when none is up
//   score      hits this game, saturating
//   misses     expired moles this game
//   hit_pulse  one-cycle strobe per registered hit
//   game_over  high while the game is over
module mole_scheduler #(
  parameter int unsigned NUM_HOLES  = 4,
  parameter int unsigned UP_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES = 12500000,
  parameter int unsigned MAX_MISSES = 3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           rnd,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           misses,
  output logic                 hit_pulse,
  output logic                 game_over
);

  localparam int unsigned IW   = $clog2(NUM_HOLES);
  localparam int unsigned TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {StIdle, StGap, StUp, StOver} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        prev_idx_q, prev_idx_d;
  logic [NUM_HOLES-1:0] btn_q;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           misses_q, misses_d;
  logic                 hit_pulse_q, hit_pulse_d;
  logic                 game_over_q, game_over_d;

  logic [NUM_HOLES-1:0] btn_rise;
  logic                 hit;
  logic                 gap_done;
  logic                 up_done;
  logic [1:0]           miss_inc;
  logic                 last_miss;
  logic [IW-1:0]        idx_raw;
  logic [IW-1:0]        idx_pick;

  // Only the low IW bits of rnd select a hole.
  logic unused_rnd;
  assign unused_rnd = ^rnd;

  assign btn_rise  = btn & ~btn_q;
  // mole_q is the one-hot of the raised hole, so masking the edges with it
  // ignores presses on every other hole.
  assign hit       = (state_q == StUp) && ((btn_rise & mole_q) != '0);
  assign gap_done  = (state_q == StGap) && (timer_q == TW'(GAP_CYCLES - 1));
  assign up_done   = (state_q == StUp) && (timer_q == TW'(UP_CYCLES - 1));
  assign miss_inc  = misses_q + 2'd1;
  assign last_miss = (miss_inc == 2'(MAX_MISSES));

  // No back-to-back repeat; wraps naturally since NUM_HOLES is a power of 2.
  assign idx_raw  = rnd[IW-1:0];
  assign idx_pick = (idx_raw == prev_idx_q) ? idx_raw + IW'(1) : idx_raw;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      prev_idx_q  <= '0;
      btn_q       <= '0;
      mole_q      <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      hit_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      prev_idx_q  <= prev_idx_d;
      btn_q       <= btn;
      mole_q      <= mole_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_pulse_q <= hit_pulse_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StGap;
      StGap:  if (gap_done) state_d = StUp;
      StUp: begin
        // A hit in the expiry cycle takes priority over the miss.
        if (hit) begin
          state_d = StGap;
        end else if (up_done) begin
          state_d = last_miss ? StOver : StGap;
        end
      end
      StOver: if (start) state_d = StGap;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the timer and the registered outputs.
  always_comb begin
    timer_d     = timer_q + TW'(1);
    prev_idx_d  = prev_idx_q;
    mole_d      = mole_q;
    score_d     = score_q;
    misses_d    = misses_q;
    hit_pulse_d = 1'b0;
    game_over_d = game_over_q;
    unique case (state_q)
      StIdle: begin
        timer_d     = '0;
        mole_d      = '0;
        game_over_d = 1'b0;
        if (start) begin
          score_d  = '0;
          misses_d = '0;
        end
      end
      StGap: begin
        mole_d = '0;
        if (gap_done) begin
          timer_d    = '0;
          prev_idx_d = idx_pick;
          mole_d     = NUM_HOLES'(1) << idx_pick;
        end
      end
      StUp: begin
        if (hit) begin
          timer_d     = '0;
          mole_d      = '0;
          hit_pulse_d = 1'b1;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end else if (up_done) begin
          timer_d  = '0;
          mole_d   = '0;
          misses_d = miss_inc;
          if (last_miss) game_over_d = 1'b1;
        end
      end
      StOver: begin
        timer_d     = '0;
        mole_d      = '0;
        game_over_d = 1'b1;
        if (start) begin
          score_d     = '0;
          misses_d    = '0;
          game_over_d = 1'b0;
        end
      end
      default: begin
        timer_d = '0;
        mole_d  = '0;
      end
    endcase
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign hit_pulse = hit_pulse_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler with short windows (UP=8, GAP=4, MAX_MISSES=3).
// A second instance with SCORE_W=2 shares all inputs to check saturation.
module tb_mole_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] rnd;
  logic [3:0] btn;

  logic [3:0] mole;
  logic [7:0] score;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       game_over;

  logic [3:0] mole2;
  logic [1:0] score2;
  logic [1:0] misses2;
  logic       hit_pulse2;
  logic       game_over2;

  int n_checks = 0;
  int n_pass   = 0;

  mole_scheduler #(
    .NUM_HOLES (4),
    .UP_CYCLES (8),
    .GAP_CYCLES(4),
    .MAX_MISSES(3),
    .SCORE_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rnd      (rnd),
    .btn      (btn),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .hit_pulse(hit_pulse),
    .game_over(game_over)
  );

  mole_scheduler #(
    .NUM_HOLES (4),
    .UP_CYCLES (8),
    .GAP_CYCLES(4),
    .MAX_MISSES(3),
    .SCORE_W   (2)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rnd      (rnd),
    .btn      (btn),
    .mole     (mole2),
    .score    (score2),
    .misses   (misses2),
    .hit_pulse(hit_pulse2),
    .game_over(game_over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] rnd;
    logic [3:0] btn;
    int         steps;
    logic [3:0] mole;
    logic [7:0] score;
    logic [1:0] misses;
    logic       hp;
    logic       go;
  } vec_t;

  function automatic vec_t mk(logic s, logic [3:0] r, logic [3:0] b, int n, logic [3:0] m,
                              logic [7:0] sc, logic [1:0] mi, logic hp, logic go);
    vec_t v;
    v.start = s; v.rnd = r; v.btn = b; v.steps = n;
    v.mole = m; v.score = sc; v.misses = mi; v.hp = hp; v.go = go;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Steps until a mole is raised, bounded so a stuck DUT cannot hang the run.
  task automatic wait_mole();
    for (int i = 0; i < 20; i++) begin
      if (mole != 4'b0) break;
      step();
    end
    check("mole_rise", {31'b0, mole != 4'b0}, 32'd1);
  endtask

  function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] prev);
    logic [1:0] i;
    i = r[1:0];
    if (i == prev) i = i + 2'd1;
    return i;
  endfunction

  vec_t       tbl[11];
  logic [1:0] prev;
  logic [1:0] idx;
  int         exp_score;
  int         hit_at[4];
  logic [3:0] rnds[4];

  initial begin
    tbl[0]  = mk(1'b1, 4'd0, 4'b0, 1, 4'b0000, 8'd0, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'd6, 4'b0, 4, 4'b0100, 8'd0, 2'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'd6, 4'b0, 7, 4'b0100, 8'd0, 2'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'd6, 4'b0, 1, 4'b0000, 8'd0, 2'd1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 4'd6, 4'b0, 3, 4'b0000, 8'd0, 2'd1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 4'd2, 4'b0, 1, 4'b1000, 8'd0, 2'd1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 4'd2, 4'b0, 8, 4'b0000, 8'd0, 2'd2, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 4'd3, 4'b0, 4, 4'b0001, 8'd0, 2'd2, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'd3, 4'b0, 8, 4'b0000, 8'd0, 2'd3, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 4'd3, 4'b0, 3, 4'b0000, 8'd0, 2'd3, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 4'd3, 4'b0, 1, 4'b0000, 8'd0, 2'd0, 1'b0, 1'b0);

    rst = 1'b1; start = 1'b0; rnd = 4'd0; btn = 4'b0;
    step();
    step();
    check("rst_mole", {28'b0, mole}, 32'd0);
    check("rst_score", {24'b0, score}, 32'd0);
    check("rst_misses", {30'b0, misses}, 32'd0);
    check("rst_hp", {31'b0, hit_pulse}, 32'd0);
    check("rst_go", {31'b0, game_over}, 32'd0);
    rst = 1'b0;

    // Full game of three unhit moles, repeat avoidance, game over and restart.
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      rnd   = tbl[i].rnd;
      btn   = tbl[i].btn;
      for (int s = 0; s < tbl[i].steps; s++) step();
      check($sformatf("v%0d_mole", i), {28'b0, mole}, {28'b0, tbl[i].mole});
      check($sformatf("v%0d_score", i), {24'b0, score}, {24'b0, tbl[i].score});
      check($sformatf("v%0d_misses", i), {30'b0, misses}, {30'b0, tbl[i].misses});
      check($sformatf("v%0d_hp", i), {31'b0, hit_pulse}, {31'b0, tbl[i].hp});
      check($sformatf("v%0d_go", i), {31'b0, game_over}, {31'b0, tbl[i].go});
    end
    start = 1'b0;
    prev  = 2'd0;

    // Hole 2 up with btn[2] held from the gap and btn[1] pressed: no score.
    // Release and re-press btn[2] in the 3rd UP cycle: hit.
    btn = 4'b0100;
    rnd = 4'd2;
    wait_mole();
    idx = pick(rnd, prev);
    prev = idx;
    check("h2_mole", {28'b0, mole}, {28'b0, 4'b0001 << idx});
    btn = 4'b0110;
    step();
    check("held_no_hp", {31'b0, hit_pulse}, 32'd0);
    check("held_no_score", {24'b0, score}, 32'd0);
    check("held_mole", {28'b0, mole}, 32'h4);
    btn = 4'b0000;
    step();
    check("rel_mole", {28'b0, mole}, 32'h4);
    btn = 4'b0100;
    step();
    check("hit_hp", {31'b0, hit_pulse}, 32'd1);
    check("hit_score", {24'b0, score}, 32'd1);
    check("hit_score_sat", {30'b0, score2}, 32'd1);
    check("hit_mole", {28'b0, mole}, 32'd0);
    step();
    check("hit_hp_once", {31'b0, hit_pulse}, 32'd0);
    check("hit_score_hold", {24'b0, score}, 32'd1);
    exp_score = 1;

    // Four more hits at various UP cycles; the first lands in the final cycle.
    hit_at = '{7, 0, 3, 5};
    rnds   = '{4'd5, 4'd7, 4'd3, 4'd8};
    for (int h = 0; h < 4; h++) begin
      btn = 4'b0;
      rnd = rnds[h];
      wait_mole();
      idx = pick(rnd, prev);
      prev = idx;
      check($sformatf("hit%0d_mole", h), {28'b0, mole}, {28'b0, 4'b0001 << idx});
      for (int s = 0; s < hit_at[h]; s++) step();
      check($sformatf("hit%0d_still_up", h), {28'b0, mole}, {28'b0, 4'b0001 << idx});
      btn = 4'b0001 << idx;
      step();
      exp_score++;
      check($sformatf("hit%0d_hp", h), {31'b0, hit_pulse}, 32'd1);
      check($sformatf("hit%0d_score", h), {24'b0, score}, exp_score);
      check($sformatf("hit%0d_score_sat", h), {30'b0, score2},
            (exp_score > 3) ? 32'd3 : exp_score);
      check($sformatf("hit%0d_misses", h), {30'b0, misses}, 32'd0);
      check($sformatf("hit%0d_mole_off", h), {28'b0, mole}, 32'd0);
    end

    // Reset mid-UP with start high: outputs clear, stays idle, prev_idx clears.
    btn = 4'b0;
    rnd = 4'd6;
    wait_mole();
    step();
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    step();
    check("mrst_mole", {28'b0, mole}, 32'd0);
    check("mrst_score", {24'b0, score}, 32'd0);
    check("mrst_misses", {30'b0, misses}, 32'd0);
    check("mrst_hp", {31'b0, hit_pulse}, 32'd0);
    check("mrst_go", {31'b0, game_over}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int s = 0; s < 6; s++) step();
    check("mrst_idle_mole", {28'b0, mole}, 32'd0);
    check("mrst_idle_go", {31'b0, game_over}, 32'd0);
    rnd = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_mole();
    check("mrst_first_mole", {28'b0, mole}, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
